// File: rtl/axisr_rr_mux_pkg.sv
// Shared types and helpers for the AXI4SR round-robin packet multiplexer.
// Latency: n/a (types, constants and a pure combinational search function).
// Backpressure: n/a.
package axisr_rr_mux_pkg;

  // Widths shared with the rest of the data path.
  localparam int AXI_DATA_BITS = 512;
  localparam int PID_BITS      = 6;

  // Upper bound on sources; the round-robin search is written for this many.
  localparam int MAX_SRC  = 16;
  localparam int IDX_BITS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // First requester found searching upward from ptr+1, wrapping modulo n.
  // Scanning from the far end down lets the nearest requester win without a break.
  function automatic logic [IDX_BITS-1:0] rr_next(
    input logic [MAX_SRC-1:0]  req,
    input logic [IDX_BITS-1:0] ptr,
    input int                  n
  );
    logic [IDX_BITS-1:0] r;
    int                  j;
    r = ptr;
    for (int k = MAX_SRC; k >= 1; k--) begin
      if (k <= n) begin
        j = (int'(ptr) + k) % n;
        if (req[j[IDX_BITS-1:0]]) r = IDX_BITS'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axisr_rr_mux_if.sv
// AXI4SR stream bundle: data, byte keep, packet id, last, valid/ready.
// Latency: n/a (wiring only).
// Backpressure: tready from the sink; m drives payload and tvalid, s drives tready.
interface axisr_rr_mux_if
  import axisr_rr_mux_pkg::*;
#(
  parameter int DATA_BITS = AXI_DATA_BITS
) ();

  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic [PID_BITS-1:0]    tid;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport m (output tdata, output tkeep, output tid, output tlast, output tvalid, input tready);
  modport s (input tdata, input tkeep, input tid, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axisr_rr_mux_arb.sv
// Round-robin arbiter: combinational search from rr_ptr+1 plus the rr_ptr register.
// Latency: gnt_idx/gnt_vld combinational from req; rr_ptr updates on the advance edge.
// Backpressure: none; the caller decides when a grant is taken by pulsing advance.
module axisr_rr_arb
  import axisr_rr_mux_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_SRC-1:0]         req,
  input  logic                     advance,
  output logic [$clog2(N_SRC)-1:0] gnt_idx,
  output logic                     gnt_vld
);
  localparam int GW = $clog2(N_SRC);

  logic [GW-1:0] rr_ptr;

  assign gnt_vld = |req;
  assign gnt_idx = GW'(rr_next(MAX_SRC'(req), IDX_BITS'(rr_ptr), N_SRC));

  // Pointer remembers the last winner; reset to the top index so source 0 goes first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr <= GW'(N_SRC - 1);
    end else if (advance) begin
      rr_ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/axisr_rr_mux.sv
// Packet-atomic round-robin merge of N_SRC AXI4SR streams into one registered output.
// Latency: one IDLE grant cycle per packet, then 1 cycle per beat to m_axis (1 beat/cycle).
// Backpressure: granted tready = !m_axis.tvalid || m_axis.tready; others held at 0.
// Option AXISR_RR_MUX_TID_TAG_EN: m_axis.tid carries the granted source index instead of s tid.
module axisr_rr_mux
  import axisr_rr_mux_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_BITS = AXI_DATA_BITS
) (
  input logic       aclk,
  input logic       aresetn,
  axisr_rr_mux_if.s s_axis [N_SRC],
  axisr_rr_mux_if.m m_axis
);
  localparam int GW = $clog2(N_SRC);
  localparam int KB = DATA_BITS / 8;

  if (N_SRC < 2 || N_SRC > MAX_SRC) begin : g_bad_nsrc
    $error("axisr_rr_mux: N_SRC must be in 2..16");
  end
  if (DATA_BITS != 512 && DATA_BITS != 1024 && DATA_BITS != 2048) begin : g_bad_width
    $error("axisr_rr_mux: DATA_BITS must be 512, 1024 or 2048");
  end
`ifdef AXISR_RR_MUX_TID_TAG_EN
  if (N_SRC > (1 << PID_BITS)) begin : g_bad_tag
    $error("axisr_rr_mux: source index does not fit in tid");
  end
`endif

  logic [N_SRC-1:0]     s_vld;
  logic [N_SRC-1:0]     s_last;
  logic [DATA_BITS-1:0] s_dat  [N_SRC];
  logic [KB-1:0]        s_keep [N_SRC];
`ifndef AXISR_RR_MUX_TID_TAG_EN
  logic [PID_BITS-1:0]  s_tid  [N_SRC];
`endif

  state_t               state;
  logic [GW-1:0]        gnt;
  logic [GW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 out_ready;
  logic                 fire;

  logic                 o_vld;
  logic [DATA_BITS-1:0] o_dat;
  logic [KB-1:0]        o_keep;
  logic [PID_BITS-1:0]  o_tid;
  logic                 o_last;

  // The output stage can take a beat when empty or draining this cycle.
  assign out_ready = !o_vld || m_axis.tready;
  assign fire      = (state == LOCKED) && s_vld[gnt] && out_ready;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign s_vld[g]  = s_axis[g].tvalid;
    assign s_last[g] = s_axis[g].tlast;
    assign s_dat[g]  = s_axis[g].tdata;
    assign s_keep[g] = s_axis[g].tkeep;
`ifndef AXISR_RR_MUX_TID_TAG_EN
    assign s_tid[g]  = s_axis[g].tid;
`endif
    assign s_axis[g].tready = (state == LOCKED) && (gnt == GW'(g)) && out_ready;
  end

  axisr_rr_arb #(
    .N_SRC (N_SRC)
  ) u_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (s_vld),
    .advance ((state == IDLE) && arb_vld),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Grant FSM: take a grant in IDLE, hold it until the tlast beat is accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            gnt   <= arb_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (fire && s_last[gnt]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on handshake, clear valid when drained, hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      o_vld  <= 1'b0;
      o_dat  <= '0;
      o_keep <= '0;
      o_tid  <= '0;
      o_last <= 1'b0;
    end else if (fire) begin
      o_vld  <= 1'b1;
      o_dat  <= s_dat[gnt];
      o_keep <= s_keep[gnt];
`ifdef AXISR_RR_MUX_TID_TAG_EN
      o_tid  <= PID_BITS'(gnt);
`else
      o_tid  <= s_tid[gnt];
`endif
      o_last <= s_last[gnt];
    end else if (m_axis.tready) begin
      o_vld  <= 1'b0;
    end
  end

  assign m_axis.tvalid = o_vld;
  assign m_axis.tdata  = o_dat;
  assign m_axis.tkeep  = o_keep;
  assign m_axis.tid    = o_tid;
  assign m_axis.tlast  = o_last;

endmodule

// File: tb/tb_axisr_rr_mux.sv
// Bench for axisr_rr_mux: per-source beat queues drive the inputs, a scoreboard checks m_axis.
// Latency: expected beat cycles are computed from the grant/bubble timing of each packet.
// Backpressure: m_axis.tready is driven always-on, stalled, or in a 1,0,0,1 pattern.
module tb_axisr_rr_mux;
  import axisr_rr_mux_pkg::*;

  localparam int N_SRC = 4;
  localparam int DB    = 512;
  localparam int KB    = DB / 8;

  typedef struct {
    logic [DB-1:0]       dat;
    logic [KB-1:0]       keep;
    logic [PID_BITS-1:0] tid;
    logic                last;
    int                  gap;
  } beat_t;

  typedef struct {
    logic [DB-1:0]       dat;
    logic [KB-1:0]       keep;
    logic [PID_BITS-1:0] tid;
    logic                last;
    int                  cyc;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_obs = 0;
  int   rdy_mode = 0;

  beat_t src_q [N_SRC][$];
  exp_t  exp_q [$];
  logic [N_SRC-1:0] rdy_vec;

  axisr_rr_mux_if #(.DATA_BITS(DB)) s_if [N_SRC] ();
  axisr_rr_mux_if #(.DATA_BITS(DB)) m_if ();

  axisr_rr_mux #(
    .N_SRC     (N_SRC),
    .DATA_BITS (DB)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis  (m_if)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] val, input logic last,
                               input logic [PID_BITS-1:0] tid, input int gap);
    beat_t b;
    b.dat  = {8{val}};
    b.keep = {~val[31:0], val[31:0] ^ 32'h5A5A_5A5A};
    b.tid  = tid;
    b.last = last;
    b.gap  = gap;
    return b;
  endfunction

  function automatic logic [PID_BITS-1:0] exp_tid(input int src, input logic [PID_BITS-1:0] tid);
`ifdef AXISR_RR_MUX_TID_TAG_EN
    return PID_BITS'(src);
`else
    return (src >= 0) ? tid : tid;
`endif
  endfunction

  task automatic push_pkt(input int src, input int n, input logic [63:0] base,
                          input logic [PID_BITS-1:0] tid, input int gap_idx, input int gap_len);
    for (int j = 0; j < n; j++)
      src_q[src].push_back(mk(base + 64'(j), j == n - 1, tid, (j == gap_idx) ? gap_len : 0));
  endtask

  task automatic expect_pkt(input int src, input int n, input logic [63:0] base,
                            input logic [PID_BITS-1:0] tid, input int cyc0);
    for (int j = 0; j < n; j++) begin
      beat_t b;
      exp_t  e;
      b      = mk(base + 64'(j), j == n - 1, tid, 0);
      e.dat  = b.dat;
      e.keep = b.keep;
      e.tid  = exp_tid(src, tid);
      e.last = b.last;
      e.cyc  = (cyc0 < 0) ? -1 : cyc0 + j;
      exp_q.push_back(e);
    end
  endtask

  // Source drivers: offer the queue head, pop it after a sampled handshake.
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign rdy_vec[g] = s_if[g].tready;
    initial begin
      logic fired;
      s_if[g].tvalid = 1'b0;
      s_if[g].tdata  = '0;
      s_if[g].tkeep  = '0;
      s_if[g].tid    = '0;
      s_if[g].tlast  = 1'b0;
      forever begin
        @(negedge aclk);
        fired = s_if[g].tvalid && s_if[g].tready;
        @(posedge aclk);
        #1;
        if (fired && src_q[g].size() > 0) void'(src_q[g].pop_front());
        if (!aresetn || src_q[g].size() == 0) begin
          s_if[g].tvalid = 1'b0;
        end else if (src_q[g][0].gap > 0) begin
          s_if[g].tvalid = 1'b0;
          src_q[g][0].gap = src_q[g][0].gap - 1;
        end else begin
          s_if[g].tvalid = 1'b1;
          s_if[g].tdata  = src_q[g][0].dat;
          s_if[g].tkeep  = src_q[g][0].keep;
          s_if[g].tid    = src_q[g][0].tid;
          s_if[g].tlast  = src_q[g][0].last;
        end
      end
    end
  end

  // Sink ready: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = stalled.
  initial begin
    int pc;
    pc = 0;
    m_if.tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        1:       m_if.tready = (pc % 4 == 0) || (pc % 4 == 3);
        2:       m_if.tready = 1'b0;
        default: m_if.tready = 1'b1;
      endcase
      pc++;
    end
  end

  // Monitor: scoreboard on accepted beats, stability while stalled, one-hot tready.
  initial begin
    logic          pv, pr, pl;
    logic [DB-1:0] pd;
    logic [KB-1:0] pk;
    exp_t          e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pk = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        pv = 1'b0;
      end else begin
        check("rdy_onehot", ($countones(rdy_vec) <= 1), 1);
        if (pv && !pr) begin
          check("hold_vld", m_if.tvalid, 1);
          check("hold_dat", m_if.tdata, pd);
          check("hold_keep", m_if.tkeep, pk);
          check("hold_last", m_if.tlast, pl);
        end
        if (m_if.tvalid && m_if.tready) begin
          n_obs++;
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat_dat", m_if.tdata, e.dat);
            check("beat_keep", m_if.tkeep, e.keep);
            check("beat_tid", m_if.tid, e.tid);
            check("beat_last", m_if.tlast, e.last);
            if (e.cyc >= 0) check("beat_cycle", cyc, e.cyc);
          end
        end
        pv = m_if.tvalid; pr = m_if.tready;
        pd = m_if.tdata;  pk = m_if.tkeep; pl = m_if.tlast;
      end
    end
  end

  // Called at a falling edge; asserts reset mid-cycle and checks the outputs clear at once.
  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    check("rst_m_vld", m_if.tvalid, 0);
    check("rst_m_dat", m_if.tdata, 0);
    check("rst_m_keep", m_if.tkeep, 0);
    check("rst_m_tid", m_if.tid, 0);
    check("rst_m_last", m_if.tlast, 0);
    check("rst_s_rdy", rdy_vec, 0);
    for (int i = 0; i < N_SRC; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(negedge aclk);
      #1;
      k++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (3) @(negedge aclk);
  endtask

  initial begin
    int p, n0, k;
    aresetn = 1'b1;
    do_reset();

    // Single 3-beat packet from source 0.
    p = cyc;
    push_pkt(0, 3, 64'hA0, 6'h01, -1, 0);
    expect_pkt(0, 3, 64'hA0, 6'h01, p + 3);
    wait_drain("t1", 50);

    // All sources busy with 2-beat packets: rotation 0,1,2,3,0,1,2,3 with one bubble each.
    do_reset();
    p = cyc;
    for (int s = 0; s < N_SRC; s++) begin
      push_pkt(s, 2, 64'h100 * s, 6'(s + 8), -1, 0);
      push_pkt(s, 2, 64'h100 * s + 64'h10, 6'(s + 8), -1, 0);
    end
    for (int q = 0; q < 2 * N_SRC; q++)
      expect_pkt(q % N_SRC, 2, 64'h100 * (q % N_SRC) + 64'h10 * (q / N_SRC),
                 6'((q % N_SRC) + 8), p + 3 + 3 * q);
    wait_drain("t2", 100);

    // Source 2 stalls mid-packet; sources 0 and 3 wait, then 3 wins the next round.
    do_reset();
    push_pkt(2, 4, 64'h200, 6'h22, 2, 5);
    expect_pkt(2, 4, 64'h200, 6'h22, -1);
    repeat (2) @(negedge aclk);
    push_pkt(0, 2, 64'h300, 6'h20, -1, 0);
    push_pkt(3, 2, 64'h400, 6'h23, -1, 0);
    expect_pkt(3, 2, 64'h400, 6'h23, -1);
    expect_pkt(0, 2, 64'h300, 6'h20, -1);
    wait_drain("t3", 100);

    // Long output stall: one beat parked in the output register, nothing else moves.
    do_reset();
    rdy_mode = 2;
    n0 = n_obs;
    push_pkt(0, 4, 64'h480, 6'h30, -1, 0);
    expect_pkt(0, 4, 64'h480, 6'h30, -1);
    repeat (20) @(negedge aclk);
    #1;
    check("stall_no_beat", n_obs - n0, 0);
    check("stall_vld", m_if.tvalid, 1);
    check("stall_src_rdy", rdy_vec, 0);
    rdy_mode = 0;
    wait_drain("t4a", 50);

    // 16-beat packet under a 1,0,0,1 ready pattern.
    rdy_mode = 1;
    push_pkt(1, 16, 64'h500, 6'h31, -1, 0);
    expect_pkt(1, 16, 64'h500, 6'h31, -1);
    wait_drain("t4b", 200);
    rdy_mode = 0;
    repeat (2) @(negedge aclk);

    // Reset during beat 5 of an 8-beat packet, then source 0 must win over source 1.
    do_reset();
    n0 = n_obs;
    push_pkt(1, 8, 64'h600, 6'h11, -1, 0);
    expect_pkt(1, 8, 64'h600, 6'h11, -1);
    k = 0;
    while (n_obs - n0 < 5 && k < 60) begin
      @(negedge aclk);
      #1;
      k++;
    end
    check("t5_beats_before_rst", n_obs - n0, 5);
    do_reset();
    push_pkt(1, 2, 64'h700, 6'h11, -1, 0);
    push_pkt(0, 2, 64'h800, 6'h10, -1, 0);
    expect_pkt(0, 2, 64'h800, 6'h10, -1);
    expect_pkt(1, 2, 64'h700, 6'h11, -1);
    wait_drain("t5", 50);

    // Two single-beat packets from source 3 with tid 0x15: one bubble between them.
    do_reset();
    p = cyc;
    push_pkt(3, 1, 64'h900, 6'h15, -1, 0);
    push_pkt(3, 1, 64'h901, 6'h15, -1, 0);
    expect_pkt(3, 1, 64'h900, 6'h15, p + 3);
    expect_pkt(3, 1, 64'h901, 6'h15, p + 5);
    wait_drain("t6", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
